// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: MMIO map, default sizing
// and the per-cycle operation classification used by the occupancy logic.
package uart_tx_fifo_pkg;

    localparam logic [31:0] UART_CTRL_ADDR = 32'h8000_0000;
    localparam logic [31:0] UART_RX_ADDR   = 32'h8000_0004;
    localparam logic [31:0] UART_TX_ADDR   = 32'h8000_0008;
    localparam logic [31:0] CYCLE_CNT_ADDR = 32'h8000_0010;
    localparam logic [31:0] INST_CNT_ADDR  = 32'h8000_0014;
    localparam logic [31:0] CNT_RST_ADDR   = 32'h8000_0018;

    localparam int TX_FIFO_DEPTH   = 8;
    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        fifo_op_e op;
        case ({push, pop})
            2'b10:   op = FIFO_PUSH;
            2'b01:   op = FIFO_POP;
            2'b11:   op = FIFO_BOTH;
            default: op = FIFO_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Store-side push port, UART-side valid/ready port and status flags of the
// transmit FIFO. The slave modport is the FIFO itself.
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = TX_FIFO_DEPTH,
    parameter int WIDTH = UART_DATA_WIDTH
) ();

    logic                     wr_en;
    logic [WIDTH-1:0]         wr_data;
    logic                     clr_ovf;
    logic [WIDTH-1:0]         tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    modport master (
        output wr_en, wr_data, clr_ovf, tx_ready,
        input  tx_data, tx_valid, full, empty, count, overflow
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_ready,
        output tx_data, tx_valid, full, empty, count, overflow
    );

endinterface

// File: rtl/uart_tx_fifo_fifo_ram.sv
// Byte storage for the transmit FIFO: synchronous write, asynchronous read.
// Contents are deliberately not reset; occupancy logic guards every read.
module fifo_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: one entry per accepted push.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the MMIO transmit-data store and the UART transmitter.
// Pointers, occupancy and flags are registered; head byte is read straight out of storage.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = TX_FIFO_DEPTH,
    parameter int WIDTH = UART_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    fifo_op_e         op_s;
    logic [WIDTH-1:0] rdata_s;

    fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_s)
    );

    // Next-state for pointers, occupancy and flags; a full FIFO drops the push even when a pop frees a slot.
    always_comb begin
        push_s   = bus.wr_en && !full_q;
        pop_s    = !empty_q && bus.tx_ready;
        drop_s   = bus.wr_en && full_q;
        op_s     = fifo_op(push_s, pop_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (op_s)
            FIFO_PUSH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + CW'(1);
            end
            FIFO_POP: begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - CW'(1);
            end
            FIFO_BOTH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q;
            end
            default: begin
                count_d = count_q;
            end
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == CW'(0));
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State registers; reset empties the queue at once so tx_valid falls without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.tx_valid = !empty_q;
    assign bus.tx_data  = rdata_s;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for fill/overflow/drain plus
// hand-written sequences for reset, latency, simultaneous push/pop, wrap and async reset.
module tb_uart_tx_fifo;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    uart_tx_fifo_if #(.DEPTH(8), .WIDTH(8)) bus ();

    uart_tx_fifo #(.DEPTH(8), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       tx_ready;
        logic       clr_ovf;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [3:0] exp_count;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic we, input logic [7:0] d, input logic rdy,
                                input logic clr, input logic v, input logic [7:0] ed,
                                input logic [3:0] c, input logic f, input logic e,
                                input logic o);
        vec_t r;
        r.wr_en = we; r.wr_data = d; r.tx_ready = rdy; r.clr_ovf = clr;
        r.exp_valid = v; r.exp_data = ed; r.exp_count = c;
        r.exp_full = f; r.exp_empty = e; r.exp_ovf = o;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [7:0] d,
                             input logic [3:0] c, input logic f, input logic e,
                             input logic o);
        chk({tag, "_valid"}, 32'(bus.tx_valid), 32'(v));
        if (v) chk({tag, "_data"}, 32'(bus.tx_data), 32'(d));
        chk({tag, "_count"}, 32'(bus.count), 32'(c));
        chk({tag, "_full"}, 32'(bus.full), 32'(f));
        chk({tag, "_empty"}, 32'(bus.empty), 32'(e));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(o));
    endtask

    task automatic drive(input logic we, input logic [7:0] d, input logic rdy, input logic clr);
        bus.wr_en    = we;
        bus.wr_data  = d;
        bus.tx_ready = rdy;
        bus.clr_ovf  = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got[$];
        int         idx;
        logic       rdy;
        logic       we;

        checks = 0;
        errors = 0;

        // Table: fill, overflow (incl. pop+push while full), clr_ovf races, drain.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 8'h00, 4'(i + 1), (i == 7), 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 8'h00, 4'd8, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 4'd8, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h09, 1'b1, 1'b0, 1'b1, 8'h01, 4'd7, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 8'h0A, 1'b0, 1'b1, 1'b1, 8'h01, 4'd8, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h0B, 1'b0, 1'b1, 1'b1, 8'h01, 4'd8, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 4'd8, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(i + 2), 4'(7 - i), 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0A, 4'd1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0));

        // Reset held with pushes requested.
        rst = 1'b0;
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("reset", 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;

        // Single byte: one-cycle latency, head stable while stalled.
        drive(1'b1, 8'h41, 1'b0, 1'b0);
        step();
        chk_state("single_push", 1'b1, 8'h41, 4'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_state("single_hold", 1'b1, 8'h41, 4'd1, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        chk_state("single_pop", 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wr_en, vecs[i].wr_data, vecs[i].tx_ready, vecs[i].clr_ovf);
            step();
            chk_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                      vecs[i].exp_count, vecs[i].exp_full, vecs[i].exp_empty, vecs[i].exp_ovf);
        end

        // Simultaneous push and pop at count 3.
        drive(1'b1, 8'hA1, 1'b0, 1'b0); step();
        drive(1'b1, 8'hA2, 1'b0, 1'b0); step();
        drive(1'b1, 8'hA3, 1'b0, 1'b0); step();
        chk_state("sim_pre", 1'b1, 8'hA1, 4'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b1, 1'b0); step();
        chk_state("sim_both", 1'b1, 8'hA2, 4'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0); step();
        chk_state("sim_d1", 1'b1, 8'hA3, 4'd2, 1'b0, 1'b0, 1'b0);
        step();
        chk_state("sim_d2", 1'b1, 8'h55, 4'd1, 1'b0, 1'b0, 1'b0);
        step();
        chk_state("sim_d3", 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);

        // Wrap-around: 20 bytes, producer respects full, ready toggles.
        idx = 0;
        rdy = 1'b1;
        for (int cyc = 0; cyc < 200 && got.size() < 20; cyc++) begin
            we = (idx < 20) && !bus.full;
            drive(we, 8'(8'h10 + idx), rdy, 1'b0);
            if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
            if (we) idx++;
            step();
            rdy = ~rdy;
        end
        chk("wrap_count", 32'(got.size()), 32'd20);
        for (int i = 0; i < got.size() && i < 20; i++)
            chk($sformatf("wrap_byte%0d", i), 32'(got[i]), 32'(8'h10 + i));
        chk("wrap_ovf", 32'(bus.overflow), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        chk_state("wrap_end", 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk_state("areset_pre", 1'b1, 8'h60, 4'd5, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_state("areset_now", 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        step();
        rst = 1'b1;
        drive(1'b1, 8'h7E, 1'b0, 1'b0);
        step();
        chk_state("areset_post", 1'b1, 8'h7E, 4'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO between the MMIO store decode for the UART transmit data address (0x80000008) and the on-chip UART transmitter's data_in/valid/ready port.
- CPU stores push bytes without stalling on the serial line. The FIFO drains into the UART whenever the transmitter is ready.
- Exposes full/empty/count and a sticky overflow flag for the MMIO status word at 0x80000000.

Parameters:
- DEPTH, 8, number of byte entries; power of two, >= 2.
- WIDTH, 8, data width in bits; equals UART data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
- wr_en  input  1  push request; one-cycle pulse from the MMIO store decode.
- wr_data  input  WIDTH  byte to push (store data [7:0]).
- clr_ovf  input  1  clears the sticky overflow flag.
- tx_data  output  WIDTH  head-of-queue byte to the UART data_in.
- tx_valid  output  1  head byte valid; drives UART data_in_valid.
- tx_ready  input  1  UART data_in_ready.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a push is dropped.

Behaviour:
- Reset (rst=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0, full=0, empty=1, tx_valid=0, overflow=0. Storage contents are not reset. Release is synchronous to clk; the first push is accepted on the first edge with rst=1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. count, full, empty and overflow are registers.
- Push accepted = wr_en && !full, using registered full at the edge. An accepted push writes mem[wr_ptr] and increments wr_ptr.
- Pop accepted = tx_valid && tx_ready. An accepted pop increments rd_ptr.
- tx_valid = !empty. tx_data = mem[rd_ptr], combinational read of registered state, so it is stable while tx_valid=1 and tx_ready=0.
- Latency: a byte pushed into an empty FIFO at edge N gives tx_valid=1 and tx_data = that byte after edge N. There is no bypass in the same cycle.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged; both pointers advance.
  - neither: unchanged.
- full=1 iff next count == DEPTH. empty=1 iff next count == 0.
- Push while full is rejected, even if a pop is accepted in the same cycle. wr_ptr and data are unchanged and overflow is set to 1 at that edge.
- overflow is cleared only by clr_ovf=1 (synchronous) or reset. If clr_ovf and a rejected push occur in the same cycle, set wins and overflow=1.
- Pop while empty cannot occur because tx_valid=0. tx_ready is ignored while empty.
- Reset mid-transfer: all queued bytes are discarded and tx_valid drops immediately (asynchronously). The UART sees valid fall and must not sample.
- Ordering is strict FIFO across any number of pointer wraps.
- Status mapping, done by the MMIO decode outside this block: 0x80000000 bit0 = !full (tx ready to accept).

Decomposition:
- Shared package holds:
  - MMIO address constants: UART_CTRL 0x80000000, UART_RX 0x80000004, UART_TX 0x80000008, CYCLE_CNT 0x80000010, INST_CNT 0x80000014, CNT_RST 0x80000018.
  - Default TX_FIFO_DEPTH = 8.
- One sub-module, fifo_ram: DEPTH x WIDTH array with synchronous write (we, waddr, wdata) and asynchronous read (raddr -> rdata). Pointer, count and flag logic stay in uart_tx_fifo.

Test Plan:
- Reset: hold rst=0 for 3 cycles with wr_en=1 -> count=0, empty=1, full=0, tx_valid=0, overflow=0 throughout.
- Single byte: push 0x41 with tx_ready=0 -> next cycle tx_valid=1, tx_data=0x41, count=1. Hold 5 cycles, then tx_ready=1 for 1 cycle -> tx_valid=0, empty=1.
- Fill and overflow: tx_ready=0, push 0x00..0x07 -> full=1, count=8. Push 0x08 -> count stays 8, overflow=1. Drain -> outputs exactly 0x00..0x07, no 0x08. Pulse clr_ovf -> overflow=0.
- Simultaneous: with count=3, assert push 0x55 and tx_ready=1 in the same cycle -> count stays 3, head advances, 0x55 appears after the two older bytes.
- Wrap-around: push 0x10..0x23 (20 bytes) with tx_ready toggling 1/0 each cycle -> output sequence 0x10..0x23 in order, no overflow.
- Reset mid-operation: count=5, tx_valid=1, assert rst=0 between clock edges -> tx_valid=0 and count=0 without waiting for an edge. After release, push 0x7E -> tx_data=0x7E, count=1.
